square_wave_monitor: RTL and testbench
======================================

Name: square_wave_monitor

Overview:
- Downstream consumer of the programmable square-wave generator output q.
- Measures each high and low phase in units of the generator's delay tick (TICK_DIV clocks) and reports them as m_meas/n_meas once per full period.
- Provides a lock indicator and a stuck-signal overflow flag, so the board can show the measured m/n and a self-check can compare them against the switch settings.

Parameters:
- N, 4: width of expected m/n; used only for the mismatch check.
- TICK_DIV, 10: clocks per measurement tick; matches the generator's 10-clock delay unit.
- CNT_W, 8: width of tick counters and measured outputs.

Ports:
- clk  input  1  system clock, shared with the generator
- reset  input  1  asynchronous, active-low reset
- q_in  input  1  square wave from the generator, synchronous to clk
- clear  input  1  synchronous flush of measurement state and flags
- m_exp  input  N  expected high count for comparison
- n_exp  input  N  expected low count for comparison
- m_meas  output  CNT_W  last measured high phase, in ticks
- n_meas  output  CNT_W  last measured low phase, in ticks
- valid  output  1  one-cycle pulse when m_meas/n_meas update
- locked  output  1  two consecutive identical measurements
- mismatch  output  1  locked, and measurement differs from {m_exp, n_exp}
- overflow  output  1  sticky; a phase exceeded 2^CNT_W-1 ticks

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE.
  - All outputs 0; q_d=0; prescaler, tick counters and previous-measurement registers 0.
- Edge detect uses a one-stage register: q_d <= q_in; rise = q_in & ~q_d; fall = ~q_in & q_d.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: ignore levels. On rise, go to HIGH with prescaler=1 and hi_ticks=0. Measurement always starts on a rising edge.
  - HIGH: count cycles where q_in=1. On fall, latch hi_round = hi_ticks + (prescaler >= TICK_DIV/2 ? 1 : 0), then go to LOW with prescaler=1 and lo_ticks=0.
  - LOW: count cycles where q_in=0. On rise, compute lo_round the same way, then:
    - register m_meas=hi_round and n_meas=lo_round, pulse valid;
    - go to HIGH, restarting the high count in that same cycle, so back-to-back periods are measured with no gap.
- Prescaler: counts 1..TICK_DIV. On reaching TICK_DIV it wraps to 1 and increments the phase tick counter. It restarts at every edge.
- Rounding rule: phase length L cycles gives round(L/TICK_DIV), with half rounding up.
  - Example: L=30 gives 3; L=4 gives 0; L=5 gives 1.
- Latency: valid is high in the cycle after the first clk edge at which q_in is sampled 1 ending a LOW phase. m_meas/n_meas change in that same cycle and hold until the next valid.
- Saturation/overflow: if a tick counter would exceed 2^CNT_W-1 while in HIGH or LOW:
  - overflow=1 (sticky), locked=0;
  - FSM goes to IDLE and no valid is pulsed;
  - m_meas/n_meas hold their previous values.
  - Covers a stuck-high or stuck-low q_in.
- locked: on each valid, locked=1 if {m_meas, n_meas} equals the previous valid's pair, else 0. The first valid after reset or clear always gives locked=0.
- mismatch: updated on each valid. Set to locked_next and (m_meas != zero-extended m_exp, or n_meas != n_exp).
  - Cleared when locked drops.
  - m_exp/n_exp changes between valids take effect at the next valid only.
- clear=1: same effect as reset, on the next clk edge. clear has priority over any simultaneous edge or valid in that cycle.
- Edge in the same cycle as saturation: saturation wins; go to IDLE, no valid.
- Glitch phases (1 cycle) are legal. They round to 0 and produce m_meas=0 or n_meas=0.
- Reset mid-phase: partial measurement discarded. Measuring resumes only after the next rise.

Test Plan:
- Generator-model q_in with 30 cycles high / 50 cycles low, repeated, m_exp=3, n_exp=5:
  - first valid gives m_meas=3, n_meas=5, locked=0;
  - second valid gives locked=1, mismatch=0.
- Same waveform with m_exp=4: mismatch=1 from the second valid on. Then change the waveform to 40/50: locked drops to 0 on the first changed period, and mismatch clears.
- Rounding: phases of 24/25/34/35 cycles give 2/3/3/4 ticks respectively.
- Stuck high: hold q_in=1 for 256*10 cycles after a rise:
  - overflow=1, locked=0, no valid;
  - a restored 30/50 waveform produces valid again while overflow stays 1 until clear pulses.
- Assert reset=0 asynchronously mid-LOW: all outputs 0 immediately. After release, no valid until one complete rise-fall-rise sequence, with values 3/5.
- Assert clear in the same cycle a valid would fire: valid stays 0 and outputs read 0.

Source files
------------

// File: rtl/square_wave_monitor.sv
`default_nettype none
// square_wave_monitor: measures high/low phases of q_in in TICK_DIV-clock ticks and
// reports them once per full period with lock, mismatch and sticky overflow flags.
module square_wave_monitor #(
    parameter int N        = 4,
    parameter int TICK_DIV = 10,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             q_in,
    input  logic             clear,
    input  logic [N-1:0]     m_exp,
    input  logic [N-1:0]     n_exp,
    output logic [CNT_W-1:0] m_meas,
    output logic [CNT_W-1:0] n_meas,
    output logic             valid,
    output logic             locked,
    output logic             mismatch,
    output logic             overflow
);
    localparam int PS_W = $clog2(TICK_DIV + 1);
    localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);
    localparam logic [PS_W-1:0] PS_MAX  = PS_W'(TICK_DIV);
    localparam logic [PS_W-1:0] PS_HALF = PS_W'((TICK_DIV + 1) / 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HIGH = 2'd1;
    localparam logic [1:0] S_LOW  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             qd_q;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [CNT_W-1:0] ticks_q, ticks_d;
    logic [CNT_W-1:0] hi_round_q, hi_round_d;
    logic [CNT_W-1:0] m_meas_q, m_meas_d;
    logic [CNT_W-1:0] n_meas_q, n_meas_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             mismatch_q, mismatch_d;
    logic             overflow_q, overflow_d;
    logic             have_prev_q, have_prev_d;

    logic             rise;
    logic             fall;
    logic [CNT_W:0]   round_sum;
    logic             sat;
    logic             meas_done;

    assign rise = q_in & ~qd_q;
    assign fall = ~q_in & qd_q;

    // The prescaler holds the cycle count inside the current tick (1..TICK_DIV),
    // so a phase ending with presc >= half a tick rounds up by one.
    assign round_sum = {1'b0, ticks_q} + {{CNT_W{1'b0}}, (presc_q >= PS_HALF)};

    // Next-state and phase-counter process
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        ticks_d    = ticks_q;
        hi_round_d = hi_round_q;
        sat        = 1'b0;
        meas_done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_HIGH;
                    presc_d = PS_ONE;
                    ticks_d = '0;
                end
            end
            S_HIGH, S_LOW: begin
                if ((state_q == S_HIGH && fall) || (state_q == S_LOW && rise)) begin
                    if (round_sum[CNT_W]) begin
                        sat = 1'b1;
                    end else begin
                        if (state_q == S_HIGH) begin
                            hi_round_d = round_sum[CNT_W-1:0];
                            state_d    = S_LOW;
                        end else begin
                            meas_done  = 1'b1;
                            state_d    = S_HIGH;
                        end
                        presc_d = PS_ONE;
                        ticks_d = '0;
                    end
                end else if (presc_q == PS_MAX) begin
                    if (ticks_q == {CNT_W{1'b1}}) begin
                        sat = 1'b1;
                    end else begin
                        presc_d = PS_ONE;
                        ticks_d = ticks_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (sat) begin
                    state_d = S_IDLE;
                    presc_d = '0;
                    ticks_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output/result process
    always_comb begin
        m_meas_d    = m_meas_q;
        n_meas_d    = n_meas_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        mismatch_d  = mismatch_q;
        overflow_d  = overflow_q;
        have_prev_d = have_prev_q;
        if (sat) begin
            overflow_d = 1'b1;
            locked_d   = 1'b0;
            mismatch_d = 1'b0;
        end else if (meas_done) begin
            m_meas_d    = hi_round_q;
            n_meas_d    = round_sum[CNT_W-1:0];
            valid_d     = 1'b1;
            locked_d    = have_prev_q && (hi_round_q == m_meas_q) &&
                          (round_sum[CNT_W-1:0] == n_meas_q);
            mismatch_d  = locked_d && ((hi_round_q != CNT_W'(m_exp)) ||
                          (round_sum[CNT_W-1:0] != CNT_W'(n_exp)));
            have_prev_d = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            qd_q        <= 1'b0;
            presc_q     <= '0;
            ticks_q     <= '0;
            hi_round_q  <= '0;
            m_meas_q    <= '0;
            n_meas_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            have_prev_q <= 1'b0;
        end else if (clear) begin
            state_q     <= S_IDLE;
            qd_q        <= 1'b0;
            presc_q     <= '0;
            ticks_q     <= '0;
            hi_round_q  <= '0;
            m_meas_q    <= '0;
            n_meas_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            overflow_q  <= 1'b0;
            have_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            qd_q        <= q_in;
            presc_q     <= presc_d;
            ticks_q     <= ticks_d;
            hi_round_q  <= hi_round_d;
            m_meas_q    <= m_meas_d;
            n_meas_q    <= n_meas_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            mismatch_q  <= mismatch_d;
            overflow_q  <= overflow_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign m_meas   = m_meas_q;
    assign n_meas   = n_meas_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign mismatch = mismatch_q;
    assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_square_wave_monitor.sv
`default_nettype none
// tb_square_wave_monitor: directed and randomized square waves, checked every cycle
// against a reference model that works in raw phase lengths (cycles), not prescaler ticks.
module tb_square_wave_monitor;
    localparam int N        = 4;
    localparam int TICK_DIV = 10;
    localparam int CNT_W    = 8;
    localparam int MAXT     = (1 << CNT_W) - 1;

    logic             clk   = 1'b0;
    logic             reset = 1'b0;
    logic             q_in  = 1'b0;
    logic             clear = 1'b0;
    logic [N-1:0]     m_exp = '0;
    logic [N-1:0]     n_exp = '0;
    logic [CNT_W-1:0] m_meas;
    logic [CNT_W-1:0] n_meas;
    logic             valid;
    logic             locked;
    logic             mismatch;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    square_wave_monitor #(.N(N), .TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .q_in     (q_in),
        .clear    (clear),
        .m_exp    (m_exp),
        .n_exp    (n_exp),
        .m_meas   (m_meas),
        .n_meas   (n_meas),
        .valid    (valid),
        .locked   (locked),
        .mismatch (mismatch),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at time %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // st: 0 waiting for a rise, 1 in high phase, 2 in low phase; len = cycles so far.
    typedef struct packed {
        int st;
        int len;
        int hr;
        int em;
        int en;
        bit ev;
        bit el;
        bit emm;
        bit eo;
        bit hp;
        bit pq;
    } mdl_t;

    mdl_t mdl = '0;

    function automatic int rnd(input int len);
        return (2 * len + TICK_DIV) / (2 * TICK_DIV);
    endfunction

    function automatic mdl_t do_sat(input mdl_t s);
        mdl_t r = s;
        r.eo  = 1'b1;
        r.el  = 1'b0;
        r.emm = 1'b0;
        r.st  = 0;
        r.len = 0;
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t s, input bit q, input int mx, input int nx);
        mdl_t ns = s;
        int   r;
        bit   ends;
        ns.ev = 1'b0;
        ns.pq = q;
        if (s.st == 0) begin
            if (q && !s.pq) begin
                ns.st  = 1;
                ns.len = 1;
            end
        end else begin
            ends = (s.st == 1) ? (!q && s.pq) : (q && !s.pq);
            if (ends) begin
                r = rnd(s.len);
                if (r > MAXT) begin
                    ns = do_sat(ns);
                end else if (s.st == 1) begin
                    ns.hr  = r;
                    ns.st  = 2;
                    ns.len = 1;
                end else begin
                    ns.ev  = 1'b1;
                    ns.el  = s.hp && (s.hr == s.em) && (r == s.en);
                    ns.emm = ns.el && ((s.hr != mx) || (r != nx));
                    ns.em  = s.hr;
                    ns.en  = r;
                    ns.hp  = 1'b1;
                    ns.st  = 1;
                    ns.len = 1;
                end
            end else if (s.len >= (MAXT + 1) * TICK_DIV) begin
                ns = do_sat(ns);
            end else begin
                ns.len = s.len + 1;
            end
        end
        return ns;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset)     mdl <= '0;
        else if (clear) mdl <= '0;
        else            mdl <= step(mdl, q_in, int'(m_exp), int'(n_exp));
    end

    always @(negedge clk) begin
        chk("cyc_m_meas",   int'(m_meas),   mdl.em);
        chk("cyc_n_meas",   int'(n_meas),   mdl.en);
        chk("cyc_valid",    int'(valid),    int'(mdl.ev));
        chk("cyc_locked",   int'(locked),   int'(mdl.el));
        chk("cyc_mismatch", int'(mismatch), int'(mdl.emm));
        chk("cyc_overflow", int'(overflow), int'(mdl.eo));
    end

    // ---------------- waveform generator ----------------
    int gen_mode = 0;      // 0: main block drives q_in, 1: periodic
    int gen_hi   = 30;
    int gen_lo   = 50;
    int gen_left = 0;
    bit gen_rand = 1'b0;
    int rh_lo = 1, rh_hi = 60, rl_lo = 1, rl_hi = 60;

    initial begin
        forever begin
            @(negedge clk);
            if (gen_mode == 1) begin
                if (gen_left <= 0) begin
                    q_in = ~q_in;
                    if (gen_rand)
                        gen_left = q_in ? int'($urandom_range(rh_hi, rh_lo))
                                        : int'($urandom_range(rl_hi, rl_lo));
                    else
                        gen_left = q_in ? gen_hi : gen_lo;
                end
                gen_left = gen_left - 1;
            end
        end
    end

    task automatic wait_valid(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_valid: no valid within %0d cycles at time %0t", maxc, $time);
        end
    endtask

    task automatic drive(input bit lvl, input int n);
        for (int i = 0; i < n; i++) begin
            q_in = lvl;
            @(negedge clk);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        bit ok;
        bit found;
        int cyc;
        int vcnt;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_meas", int'(m_meas), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_overflow", int'(overflow), 0);
        reset = 1'b1;

        // 30/50 waveform, expected 3/5
        m_exp = 4'd3; n_exp = 4'd5;
        gen_hi = 30; gen_lo = 50; gen_left = 0; gen_mode = 1;
        wait_valid(300, ok);
        chk("p1_m", int'(m_meas), 3);
        chk("p1_n", int'(n_meas), 5);
        chk("p1_locked", int'(locked), 0);
        wait_valid(120, ok);
        chk("p2_locked", int'(locked), 1);
        chk("p2_mismatch", int'(mismatch), 0);

        // wrong expectation, then waveform change to 40/50
        m_exp = 4'd4;
        wait_valid(120, ok);
        chk("mx_locked", int'(locked), 1);
        chk("mx_mismatch", int'(mismatch), 1);
        gen_hi = 40;
        found = 1'b0;
        for (int k = 0; k < 4 && !found; k++) begin
            wait_valid(150, ok);
            if (m_meas == 8'd4) found = 1'b1;
        end
        chk("chg_found", int'(found), 1);
        chk("chg_locked", int'(locked), 0);
        chk("chg_mismatch", int'(mismatch), 0);
        wait_valid(150, ok);
        chk("chg2_locked", int'(locked), 1);
        chk("chg2_mismatch", int'(mismatch), 0);

        // rounding boundaries
        gen_hi = 24; gen_lo = 25;
        repeat (3) wait_valid(150, ok);
        chk("rnd24_m", int'(m_meas), 2);
        chk("rnd25_n", int'(n_meas), 3);
        gen_hi = 34; gen_lo = 35;
        repeat (3) wait_valid(150, ok);
        chk("rnd34_m", int'(m_meas), 3);
        chk("rnd35_n", int'(n_meas), 4);
        chk("rnd_locked", int'(locked), 1);

        // stuck high after a rise
        wait_valid(150, ok);
        gen_mode = 0;
        q_in = 1'b1;
        vcnt = 0;
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (overflow) begin
                found = 1'b1;
                break;
            end
        end
        chk("stuck_overflow", int'(found), 1);
        chk("stuck_no_valid", vcnt, 0);
        chk("stuck_locked", int'(locked), 0);
        chk("stuck_hold_m", int'(m_meas), 3);
        chk("stuck_hold_n", int'(n_meas), 4);

        gen_hi = 30; gen_lo = 50; gen_left = 0; gen_mode = 1;
        wait_valid(300, ok);
        chk("rest_m", int'(m_meas), 3);
        chk("rest_n", int'(n_meas), 5);
        chk("rest_overflow", int'(overflow), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clr_overflow", int'(overflow), 0);
        chk("clr_m", int'(m_meas), 0);

        // asynchronous reset in the middle of a low phase
        wait_valid(300, ok);
        chk("pre_rst_m", int'(m_meas), 3);
        repeat (40) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_m", int'(m_meas), 0);
        chk("arst_n", int'(n_meas), 0);
        chk("arst_valid", int'(valid), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_mismatch", int'(mismatch), 0);
        chk("arst_overflow", int'(overflow), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("arst_found", int'(found), 1);
        chk("arst_full_period", int'(cyc >= 80), 1);
        chk("arst_m_after", int'(m_meas), 3);
        chk("arst_n_after", int'(n_meas), 5);
        chk("arst_locked_after", int'(locked), 0);

        // clear coincident with the rise that would produce valid
        @(negedge clk);
        gen_mode = 0;
        drive(1'b0, 60);
        drive(1'b1, 30);
        drive(1'b0, 50);
        drive(1'b1, 30);
        drive(1'b0, 50);
        chk("pre_clr_m", int'(m_meas), 3);
        q_in  = 1'b1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clrv_valid", int'(valid), 0);
        chk("clrv_m", int'(m_meas), 0);
        chk("clrv_n", int'(n_meas), 0);
        chk("clrv_locked", int'(locked), 0);
        drive(1'b1, 20);

        // random phases including 1-cycle glitches
        gen_rand = 1'b1;
        rh_lo = 1; rh_hi = 60; rl_lo = 1; rl_hi = 60;
        gen_left = 0; gen_mode = 1;
        for (int i = 0; i < 8; i++) begin
            m_exp = N'($urandom_range(15, 0));
            n_exp = N'($urandom_range(15, 0));
            repeat (500) @(negedge clk);
        end

        // near-nominal jitter: lock held, expectation toggled between right and wrong
        rh_lo = 29; rh_hi = 31; rl_lo = 49; rl_hi = 51;
        for (int i = 0; i < 6; i++) begin
            m_exp = (i % 2 == 0) ? 4'd3 : 4'd2;
            n_exp = 4'd5;
            repeat (400) @(negedge clk);
        end
        chk("jit_locked", int'(locked), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
